serial_mag_comparator: RTL

- Multi-cycle magnitude comparator for wide operands. It compares one 4-bit digit per clock, LSB digit first, carrying the running L/E/G relation in registers from cycle to cycle.
- This is the reverse-direction counterpart of the parallel MSB-priority cascade comparator. The cascade relation flows upward in time instead of across gates, so later (more significant) digits override earlier ones.
- It sits beside the combinational comparators for operand widths where a single-cycle cascade is too wide or too slow. It takes external cascade inputs, so it can extend a lower-order comparison.

---
 rtl/serial_mag_comparator.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/serial_mag_comparator.sv
// Purpose: digit-serial unsigned magnitude comparator. It compares one 4-bit digit per clock, LSB digit first.
// Latency: an accepted start gives a done pulse NDIG+1 cycles later. Throughput is one compare per NDIG+2 cycles.
// Backpressure: none. start is honoured only in IDLE and is dropped otherwise. abort cancels a compare that is running.
`timescale 1ns/1ps
module serial_mag_comparator #(
    parameter int WIDTH = 16,
    parameter int NDIG  = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Li,
    input  logic             Ei,
    input  logic             Gi,
    output logic             busy,
    output logic             done,
    output logic             Lo,
    output logic             Eo,
    output logic             Go
);

    // The digit counter is at least one bit wide, so a single-digit build still has a register.
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REL_LT = 2'd0,
        REL_EQ = 2'd1,
        REL_GT = 2'd2
    } rel_t;

    state_t           state_q;
    rel_t             rel_q;
    rel_t             rel_init_d;
    rel_t             rel_d;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             busy_q;
    logic             done_q;
    logic             lo_q;
    logic             eo_q;
    logic             go_q;
    logic [3:0]       a_dig;
    logic [3:0]       b_dig;
    logic             last_dig;

    assign a_dig    = a_sr_q[3:0];
    assign b_dig    = b_sr_q[3:0];
    assign last_dig = (cnt_q == LAST_DIG);
    assign cnt_d    = cnt_q + CW'(1);

    // Seed relation from the cascade inputs. Ei wins over Li, Li wins over Gi, and all-zero counts as equal.
    always_comb begin
        rel_init_d = REL_EQ;
        if (Ei) begin
            rel_init_d = REL_EQ;
        end else if (Li) begin
            rel_init_d = REL_LT;
        end else if (Gi) begin
            rel_init_d = REL_GT;
        end
    end

    // A differing digit overrides the running relation. Digits arrive LSB first, so the last difference seen decides.
    always_comb begin
        rel_d = rel_q;
        if (a_dig > b_dig) begin
            rel_d = REL_GT;
        end else if (a_dig < b_dig) begin
            rel_d = REL_LT;
        end
    end

    // Control FSM and datapath. Every output is registered. The result is published on the edge that leaves DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rel_q   <= REL_EQ;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lo_q    <= 1'b0;
            eo_q    <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // When start and abort arrive together, the start is taken because abort only applies to RUN.
                    if (start) begin
                        a_sr_q  <= A;
                        b_sr_q  <= B;
                        cnt_q   <= '0;
                        rel_q   <= rel_init_d;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        // A cancelled compare also clears the previous result.
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        lo_q    <= 1'b0;
                        eo_q    <= 1'b0;
                        go_q    <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        rel_q  <= rel_d;
                        a_sr_q <= a_sr_q >> 4;
                        b_sr_q <= b_sr_q >> 4;
                        if (last_dig) begin
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                S_DONE: begin
                    // The final relation is already in rel_q. Publish it one-hot together with the done pulse.
                    done_q  <= 1'b1;
                    lo_q    <= (rel_q == REL_LT);
                    eo_q    <= (rel_q == REL_EQ);
                    go_q    <= (rel_q == REL_GT);
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Lo   = lo_q;
    assign Eo   = eo_q;
    assign Go   = go_q;

endmodule
